// File: rtl/orao_video_pkg.sv
// Shared definitions for the Orao video datapath.
// Holds the line geometry, the video RAM address width, the line-fill
// state encoding and a saturating increment helper for event counters.
package orao_video_pkg;

  localparam int LINE_BYTES = 32;
  localparam int LINES      = 256;
  localparam int VRAM_AW    = 13;

  typedef enum logic [1:0] {
    FILL_CUR  = 2'd0,
    FILL_NEXT = 2'd1,
    DONE      = 2'd2
  } fill_state_t;

  // Add one to an 8-bit counter, sticking at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/orao_vram_line_prefetch_if.sv
// Fetch port between the line prefetcher and the shared video RAM arbiter.
//   mem_req   : fetch request, held until acked
//   mem_addr  : byte address, stable while mem_req=1 and mem_ack=0
//   mem_ack   : one byte transferred this cycle
//   mem_rdata : fetched byte, valid with mem_ack
// master = prefetcher side, slave = arbiter / RAM side.
interface orao_vram_line_prefetch_if #(
  parameter int ADDR_W = 13
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/orao_line_bank.sv
// Two-bank line buffer (2 x LINE_BYTES x 8), intended for LUT RAM.
//   clk_pixel, reset : clock, synchronous active-high reset (read register only)
//   wr_en/wr_bank/wr_idx/wr_data : write port
//   rd_bank/rd_idx   : read address
//   rd_data          : registered read data, one cycle after the address
module orao_line_bank
  import orao_video_pkg::*;
#(
  parameter int LINE_LOG2 = 5
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 wr_bank,
  input  logic [LINE_LOG2-1:0] wr_idx,
  input  logic [7:0]           wr_data,
  input  logic                 rd_bank,
  input  logic [LINE_LOG2-1:0] rd_idx,
  output logic [7:0]           rd_data
);

  logic [7:0] mem_r [2**(LINE_LOG2+1)];

  // Write port: no reset so the array stays mappable to distributed RAM.
  always_ff @(posedge clk_pixel) begin
    if (wr_en) begin
      mem_r[{wr_bank, wr_idx}] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= mem_r[{rd_bank, rd_idx}];
    end
  end

endmodule

// File: rtl/orao_vram_line_prefetch.sv
// Line prefetcher for the Orao display: serves display byte reads from a
// two-bank line buffer and fills it from shared video RAM ahead of the beam.
//   clk_pixel, reset : pixel clock, synchronous active-high reset
//   disp_addr        : display byte address ([12:5] line, [4:0] byte)
//   disp_data        : byte at disp_addr, one cycle later
//   mem              : fetch port (master modport)
//   line_ready       : active bank holds the complete current line
//   underrun         : sticky, a line became current before it was complete
//   underrun_cnt     : saturating count of underrun events
module orao_vram_line_prefetch
  import orao_video_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int LINE_LOG2  = 5,
  parameter int FILL_AHEAD = 1
) (
  input  logic                      clk_pixel,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         disp_addr,
  output logic [7:0]                disp_data,
  orao_vram_line_prefetch_if.master mem,
  output logic                      line_ready,
  output logic                      underrun,
  output logic [7:0]                underrun_cnt
);

  localparam int LW = ADDR_W - LINE_LOG2;

  fill_state_t          state_r, state_s;
  logic                 active_r, active_s;
  logic [LW-1:0]        cur_line_r, cur_line_s;
  logic [1:0]           full_r, full_s;
  logic [LINE_LOG2-1:0] idx_r, idx_s;
  logic                 mem_req_r, mem_req_s;
  logic [ADDR_W-1:0]    mem_addr_r, mem_addr_s;
  logic                 line_ready_r, line_ready_s;
  logic                 underrun_r, underrun_s;
  logic [7:0]           cnt_r, cnt_s;
  logic                 wr_en_s, wr_bank_s, last_s, free_s, ev_s;
  logic [LW-1:0]        disp_line_s, next_line_s, fill_line_s;

  // Next state: the acked byte is applied first, then any line change on
  // top of it. Line changes wait while a request is pending without ack.
  always_comb begin
    disp_line_s = disp_addr[ADDR_W-1:LINE_LOG2];
    next_line_s = cur_line_r + LW'(1);
    wr_en_s     = mem_req_r && mem.mem_ack;
    free_s      = !mem_req_r || mem.mem_ack;
    last_s      = (idx_r == {LINE_LOG2{1'b1}});
    state_s     = state_r;
    active_s    = active_r;
    cur_line_s  = cur_line_r;
    full_s      = full_r;
    idx_s       = idx_r;
    ev_s        = 1'b0;

    case (state_r)
      FILL_CUR: wr_bank_s = active_r;
      default:  wr_bank_s = ~active_r;
    endcase

    if (wr_en_s) begin
      idx_s = idx_r + {{(LINE_LOG2-1){1'b0}}, 1'b1};
      if (last_s) begin
        full_s[wr_bank_s] = 1'b1;
        case (state_r)
          FILL_CUR: state_s = (FILL_AHEAD != 0) ? FILL_NEXT : DONE;
          default:  state_s = DONE;
        endcase
      end else begin
        state_s = state_r;
      end
    end else begin
      idx_s = idx_r;
    end

    if (!free_s || (disp_line_s == cur_line_r)) begin
      ev_s = 1'b0;
    end else if (disp_line_s == next_line_s) begin
      // Swap: the old active bank becomes the prefetch target.
      active_s         = ~active_r;
      cur_line_s       = next_line_s;
      full_s[active_r] = 1'b0;
      if (full_s[~active_r]) begin
        state_s = (FILL_AHEAD != 0) ? FILL_NEXT : DONE;
        idx_s   = {LINE_LOG2{1'b0}};
      end else if (state_s == FILL_NEXT) begin
        // Partial prefetch of this very line: keep going from idx.
        ev_s    = 1'b1;
        state_s = FILL_CUR;
      end else begin
        ev_s    = 1'b1;
        state_s = FILL_CUR;
        idx_s   = {LINE_LOG2{1'b0}};
      end
    end else begin
      ev_s       = 1'b1;
      cur_line_s = disp_line_s;
      full_s     = 2'b00;
      state_s    = FILL_CUR;
      idx_s      = {LINE_LOG2{1'b0}};
    end

    if (state_s == FILL_CUR) begin
      fill_line_s = cur_line_s;
    end else begin
      fill_line_s = cur_line_s + LW'(1);
    end
    mem_req_s    = (state_s != DONE);
    mem_addr_s   = mem_req_s ? {fill_line_s, idx_s} : mem_addr_r;
    line_ready_s = full_s[active_s];
    underrun_s   = underrun_r | ev_s;
    cnt_s        = ev_s ? sat_inc8(cnt_r) : cnt_r;
  end

  // State and registered outputs.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_r      <= FILL_CUR;
      active_r     <= 1'b0;
      cur_line_r   <= {LW{1'b0}};
      full_r       <= 2'b00;
      idx_r        <= {LINE_LOG2{1'b0}};
      mem_req_r    <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      line_ready_r <= 1'b0;
      underrun_r   <= 1'b0;
      cnt_r        <= 8'h00;
    end else begin
      state_r      <= state_s;
      active_r     <= active_s;
      cur_line_r   <= cur_line_s;
      full_r       <= full_s;
      idx_r        <= idx_s;
      mem_req_r    <= mem_req_s;
      mem_addr_r   <= mem_addr_s;
      line_ready_r <= line_ready_s;
      underrun_r   <= underrun_s;
      cnt_r        <= cnt_s;
    end
  end

  orao_line_bank #(.LINE_LOG2(LINE_LOG2)) u_bank (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .wr_en     (wr_en_s),
    .wr_bank   (wr_bank_s),
    .wr_idx    (idx_r),
    .wr_data   (mem.mem_rdata),
    .rd_bank   (active_r),
    .rd_idx    (disp_addr[LINE_LOG2-1:0]),
    .rd_data   (disp_data)
  );

  assign mem.mem_req   = mem_req_r;
  assign mem.mem_addr  = mem_addr_r;
  assign line_ready    = line_ready_r;
  assign underrun      = underrun_r;
  assign underrun_cnt  = cnt_r;

endmodule
